// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, the halt opcode and the opcode-field helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fc_state_t;

  localparam logic [3:0] HALT_OP = 4'b1111;

  // The opcode is the top nibble of an instruction that is `width` bits wide.
  function automatic logic [3:0] opcode_field(input logic [63:0] word, input int unsigned width);
    return 4'(word >> (width - 4));
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
// Counts one per cycle while inc is high and holds once it reaches all-ones.
import fetch_ctrl_pkg::*;

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: arbitrates branch redirects, downstream stalls and halt,
// inserts flush bubbles after a redirect and keeps saturating stall/flush counters.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 6,
  parameter int FLUSH_CYCLES     = 1,
  parameter int CNT_W            = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall_req,
  input  logic                        branch_taken,
  input  logic [MEMORY_ADDR_SIZE-1:0] branch_target,
  input  logic [ARQ-1:0]              instr,
  output logic                        pc_en,
  output logic                        mux_sel,
  output logic [MEMORY_ADDR_SIZE-1:0] branch_addr,
  output logic                        if_id_en,
  output logic                        if_id_flush,
  output logic                        halted,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  localparam int               BUB_W      = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(FLUSH_CYCLES);
  // With no bubble cycles configured a redirect goes straight back to RUN.
  localparam fc_state_t        BR_NEXT    = (FLUSH_CYCLES == 0) ? RUN : FLUSH;

  fc_state_t        state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic             stall_inc;
  logic             flush_inc;
  logic             is_halt;

  assign is_halt = (opcode_field(64'(instr), ARQ) == HALT_OP);

  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    pc_en       = 1'b0;
    mux_sel     = 1'b0;
    branch_addr = '0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (branch_taken) begin
          pc_en       = 1'b1;
          mux_sel     = 1'b1;
          branch_addr = branch_target;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          bub_d       = BUB_RELOAD;
          state_d     = BR_NEXT;
        end else if (is_halt) begin
          if_id_en = 1'b1;
          state_d  = HALT;
        end else if (stall_req) begin
          stall_inc = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end

      // The instruction in IF is being squashed here, so a halt opcode is not decoded.
      FLUSH: begin
        if (branch_taken) begin
          pc_en       = 1'b1;
          mux_sel     = 1'b1;
          branch_addr = branch_target;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          bub_d       = BUB_RELOAD;
          state_d     = BR_NEXT;
        end else if (stall_req) begin
          stall_inc = 1'b1;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          bub_d       = bub_q - 1'b1;
          if (bub_q <= BUB_W'(1)) begin
            state_d = RUN;
          end
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: dut_a uses the default configuration,
// dut_b uses FLUSH_CYCLES=2 and 2-bit counters for saturation and reload cases.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall_req;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic [15:0] instr;

  logic       pc_en_a, mux_sel_a, if_id_en_a, if_id_flush_a, halted_a;
  logic [5:0] branch_addr_a;
  logic [7:0] stall_cnt_a, flush_cnt_a;

  logic       pc_en_b, mux_sel_b, if_id_en_b, if_id_flush_b, halted_b;
  logic [5:0] branch_addr_b;
  logic [1:0] stall_cnt_b, flush_cnt_b;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.ARQ(16), .MEMORY_ADDR_SIZE(6), .FLUSH_CYCLES(1), .CNT_W(8)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .pc_en         (pc_en_a),
    .mux_sel       (mux_sel_a),
    .branch_addr   (branch_addr_a),
    .if_id_en      (if_id_en_a),
    .if_id_flush   (if_id_flush_a),
    .halted        (halted_a),
    .stall_cnt     (stall_cnt_a),
    .flush_cnt     (flush_cnt_a)
  );

  fetch_ctrl #(.ARQ(16), .MEMORY_ADDR_SIZE(6), .FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .pc_en         (pc_en_b),
    .mux_sel       (mux_sel_b),
    .branch_addr   (branch_addr_b),
    .if_id_en      (if_id_en_b),
    .if_id_flush   (if_id_flush_b),
    .halted        (halted_b),
    .stall_cnt     (stall_cnt_b),
    .flush_cnt     (flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: inputs change just after a rising edge, outputs are observed at the falling edge.
  task automatic applyStimulus(input logic st, input logic stl, input logic br,
                               input logic [5:0] tgt, input logic [15:0] ins);
    @(posedge clk);
    #1;
    start         = st;
    stall_req     = stl;
    branch_taken  = br;
    branch_target = tgt;
    instr         = ins;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    start         = 1'b0;
    stall_req     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    instr         = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkIdleA(input string tag);
    checkOutput({tag, ".pc_en"},       32'(pc_en_a),       0);
    checkOutput({tag, ".mux_sel"},     32'(mux_sel_a),     0);
    checkOutput({tag, ".branch_addr"}, 32'(branch_addr_a), 0);
    checkOutput({tag, ".if_id_en"},    32'(if_id_en_a),    0);
    checkOutput({tag, ".if_id_flush"}, 32'(if_id_flush_a), 0);
    checkOutput({tag, ".halted"},      32'(halted_a),      0);
    checkOutput({tag, ".stall_cnt"},   32'(stall_cnt_a),   0);
    checkOutput({tag, ".flush_cnt"},   32'(flush_cnt_a),   0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    stall_req     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    instr         = '0;
    #23;
    checkIdleA("reset");
    rst = 1'b0;

    // Start and plain fetching
    applyStimulus(1, 0, 0, 6'd0, 16'h0000);
    checkOutput("idle_start.pc_en", 32'(pc_en_a), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 6'd0, 16'h1234);
      checkOutput("run.pc_en",     32'(pc_en_a),     1);
      checkOutput("run.mux_sel",   32'(mux_sel_a),   0);
      checkOutput("run.if_id_en",  32'(if_id_en_a),  1);
      checkOutput("run.flush",     32'(if_id_flush_a), 0);
      checkOutput("run.stall_cnt", 32'(stall_cnt_a), 0);
      checkOutput("run.flush_cnt", 32'(flush_cnt_a), 0);
    end

    // Redirect followed by one bubble
    applyStimulus(0, 0, 1, 6'b001101, 16'h0000);
    checkOutput("br.mux_sel",     32'(mux_sel_a),     1);
    checkOutput("br.branch_addr", 32'(branch_addr_a), 13);
    checkOutput("br.pc_en",       32'(pc_en_a),       1);
    checkOutput("br.flush",       32'(if_id_flush_a), 1);
    applyStimulus(0, 0, 0, 6'b001101, 16'h0000);
    checkOutput("bub.flush",       32'(if_id_flush_a), 1);
    checkOutput("bub.mux_sel",     32'(mux_sel_a),     0);
    checkOutput("bub.branch_addr", 32'(branch_addr_a), 0);
    checkOutput("bub.flush_cnt",   32'(flush_cnt_a),   1);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("after_bub.flush", 32'(if_id_flush_a), 0);
    checkOutput("after_bub.pc_en", 32'(pc_en_a),       1);

    // Three stall cycles in RUN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 6'd0, 16'h0000);
      checkOutput("stall.pc_en",    32'(pc_en_a),    0);
      checkOutput("stall.if_id_en", 32'(if_id_en_a), 0);
      checkOutput("stall.cnt",      32'(stall_cnt_a), i);
    end
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("unstall.pc_en", 32'(pc_en_a),     1);
    checkOutput("unstall.cnt",   32'(stall_cnt_a), 3);

    // Branch beats stall, then a stall inside FLUSH holds the bubble
    applyStimulus(0, 1, 1, 6'h2A, 16'h0000);
    checkOutput("br_stall.mux_sel", 32'(mux_sel_a),     1);
    checkOutput("br_stall.pc_en",   32'(pc_en_a),       1);
    checkOutput("br_stall.addr",    32'(branch_addr_a), 42);
    applyStimulus(0, 1, 0, 6'd0, 16'h0000);
    checkOutput("fl_stall.pc_en",     32'(pc_en_a),     0);
    checkOutput("fl_stall.if_id_en",  32'(if_id_en_a),  0);
    checkOutput("fl_stall.stall_cnt", 32'(stall_cnt_a), 3);
    checkOutput("fl_stall.flush_cnt", 32'(flush_cnt_a), 2);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("fl_held.flush",     32'(if_id_flush_a), 1);
    checkOutput("fl_held.pc_en",     32'(pc_en_a),       1);
    checkOutput("fl_held.stall_cnt", 32'(stall_cnt_a),   4);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("fl_done.flush", 32'(if_id_flush_a), 0);

    // Halt overrides stall, then nothing but reset leaves HALT
    applyStimulus(0, 1, 0, 6'd0, 16'hF000);
    checkOutput("halt.pc_en",    32'(pc_en_a),    0);
    checkOutput("halt.if_id_en", 32'(if_id_en_a), 1);
    checkOutput("halt.halted",   32'(halted_a),   0);
    applyStimulus(1, 0, 1, 6'd5, 16'h0000);
    checkOutput("halted.halted",   32'(halted_a),      1);
    checkOutput("halted.pc_en",    32'(pc_en_a),       0);
    checkOutput("halted.mux_sel",  32'(mux_sel_a),     0);
    checkOutput("halted.addr",     32'(branch_addr_a), 0);
    checkOutput("halted.if_id_en", 32'(if_id_en_a),    0);
    checkOutput("halted.stall",    32'(stall_cnt_a),   4);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("halted2.halted", 32'(halted_a), 1);
    #1;
    rst = 1'b1;
    #1;
    checkIdleA("halt_reset");

    // Saturation and bubble reload on the second configuration
    doReset();
    applyStimulus(1, 0, 0, 6'd0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 6'd0, 16'h0000);
    end
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("sat.stall_cnt", 32'(stall_cnt_b), 3);
    checkOutput("sat.pc_en",     32'(pc_en_b),     1);
    applyStimulus(0, 0, 1, 6'd7, 16'h0000);
    checkOutput("b_br.mux_sel", 32'(mux_sel_b),     1);
    checkOutput("b_br.addr",    32'(branch_addr_b), 7);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("b_bub1.flush", 32'(if_id_flush_b), 1);
    applyStimulus(0, 0, 1, 6'd9, 16'hF000);
    checkOutput("b_rebr.mux_sel", 32'(mux_sel_b),     1);
    checkOutput("b_rebr.addr",    32'(branch_addr_b), 9);
    checkOutput("b_rebr.flush",   32'(if_id_flush_b), 1);
    applyStimulus(0, 0, 0, 6'd0, 16'hF000);
    checkOutput("b_re1.flush",   32'(if_id_flush_b), 1);
    checkOutput("b_re1.mux_sel", 32'(mux_sel_b),     0);
    checkOutput("b_re1.pc_en",   32'(pc_en_b),       1);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("b_re2.flush",  32'(if_id_flush_b), 1);
    checkOutput("b_re2.halted", 32'(halted_b),      0);
    applyStimulus(0, 0, 0, 6'd0, 16'h0000);
    checkOutput("b_run.flush",     32'(if_id_flush_b), 0);
    checkOutput("b_run.pc_en",     32'(pc_en_b),       1);
    checkOutput("b_run.flush_cnt", 32'(flush_cnt_b),   2);
    checkOutput("b_run.halted",    32'(halted_b),      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
